// File: rtl/lsu_pkg.sv
// Shared types, width codes and memory-region bounds for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LD    = 2'd1,
    S_ST_RD = 2'd2,
    S_ST_WR = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int unsigned MEM_WORDS  = 256;
  localparam int unsigned TEXT_WORDS = 64;
  localparam logic [31:0] MEM_LIMIT  = 32'(4 * MEM_WORDS);
  localparam logic [31:0] TEXT_LIMIT = 32'(4 * TEXT_WORDS);

  // Requests rejected before any memory access: bad width code, misalignment,
  // out of range, or a store into the instruction region.
  function automatic logic req_fault(input logic       is_store,
                                     input logic [2:0]  funct3,
                                     input logic [31:0] addr);
    logic bad_f3;
    logic misaligned;
    bad_f3     = 1'b0;
    misaligned = 1'b0;
    case (funct3)
      F3_B:    bad_f3 = 1'b0;
      F3_H:    misaligned = addr[0];
      F3_W:    misaligned = |addr[1:0];
      F3_BU:   bad_f3 = is_store;
      F3_HU: begin
        bad_f3     = is_store;
        misaligned = addr[0];
      end
      default: bad_f3 = 1'b1;
    endcase
    return bad_f3 | misaligned | (addr >= MEM_LIMIT) | (is_store & (addr < TEXT_LIMIT));
  endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Byte-lane datapath: load extract/extend and sub-word store merge.
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic [31:0] rd_word,
  input  logic [31:0] old_word,
  input  logic [31:0] new_data,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] load_result,
  output logic [31:0] store_word
);

  logic [31:0] shifted;

  assign shifted = rd_word >> {offset, 3'b000};

  always_comb begin
    case (funct3)
      F3_B:    load_result = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   load_result = {24'h0, shifted[7:0]};
      F3_H:    load_result = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   load_result = {16'h0, shifted[15:0]};
      default: load_result = rd_word;
    endcase
  end

  // Word stores bypass the merge and write the new data whole.
  always_comb begin
    store_word = old_word;
    case (funct3)
      F3_B:    store_word[{offset, 3'b000} +: 8]         = new_data[7:0];
      F3_H:    store_word[{offset[1], 4'b0000} +: 16]    = new_data[15:0];
      default: store_word = new_data;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store sequencer driving the word-addressed data memory port.
//   state   | meaning
//   S_IDLE  | waiting for start; faults are answered from here
//   S_LD    | memory read, extended result registered into load_data
//   S_ST_RD | sub-word store: old word captured into old_q
//   S_ST_WR | memory write cycle, write lands on the closing edge
module load_store_unit
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_write,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [31:0] load_data
);

  lsu_state_e  state;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] old_q;
  logic [2:0]  f3_q;
  logic        store_q;
  logic [31:0] ld_ext;
  logic [31:0] st_word;

  lsu_byte_lane u_lane (
    .rd_word     (mem_rdata),
    .old_word    (old_q),
    .new_data    (wdata_q),
    .offset      (addr_q[1:0]),
    .funct3      (f3_q),
    .load_result (ld_ext),
    .store_word  (st_word)
  );

  // Decoded from flops only, so an async reset kills the write immediately.
  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign mem_write = (state == S_ST_WR) && store_q;
  assign mem_wdata = mem_write ? st_word : 32'h0;
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      addr_q    <= 32'h0;
      wdata_q   <= 32'h0;
      old_q     <= 32'h0;
      f3_q      <= 3'b000;
      store_q   <= 1'b0;
      load_data <= 32'h0;
      done      <= 1'b0;
      fault     <= 1'b0;
    end else begin
      done  <= 1'b0;
      fault <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            addr_q  <= addr;
            wdata_q <= wdata;
            f3_q    <= funct3;
            store_q <= is_store;
            if (req_fault(is_store, funct3, addr)) begin
              done  <= 1'b1;
              fault <= 1'b1;
            end else if (!is_store) begin
              state <= S_LD;
            end else if (funct3 == F3_W) begin
              state <= S_ST_WR;
            end else begin
              state <= S_ST_RD;
            end
          end
        end
        S_LD: begin
          load_data <= ld_ext;
          done      <= 1'b1;
          state     <= S_IDLE;
        end
        S_ST_RD: begin
          old_q <= mem_rdata;
          state <= S_ST_WR;
        end
        S_ST_WR: begin
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit with a request-level reference model and memory.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        is_store = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] mem_rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_write;
  logic        busy;
  logic        done;
  logic        fault;
  logic [31:0] load_data;

  logic [31:0] data_mem [256];
  logic [31:0] ref_mem  [256];
  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;

  load_store_unit dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .is_store  (is_store),
    .funct3    (funct3),
    .addr      (addr),
    .wdata     (wdata),
    .mem_rdata (mem_rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_write (mem_write),
    .busy      (busy),
    .done      (done),
    .fault     (fault),
    .load_data (load_data)
  );

  always #5 clk = ~clk;

  assign mem_rdata = data_mem[mem_addr[9:2]];
  always @(posedge clk) if (mem_write) data_mem[mem_addr[9:2]] <= mem_wdata;
  always @(negedge clk) if (mem_write) wr_cnt++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Access size in bytes; 0 marks an illegal width code.
  function automatic int unsigned size_of(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  function automatic bit model_fault(input bit st, input logic [2:0] f3, input logic [31:0] a);
    int unsigned n;
    n = size_of(f3);
    if (n == 0) return 1'b1;
    if (st && f3[2]) return 1'b1;
    if ((a % n) != 0) return 1'b1;
    if (a >= 32'd1024) return 1'b1;
    if (st && a < 32'd256) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [2:0] f3,
                                             input logic [1:0] off);
    longint v;
    int unsigned n;
    logic [63:0] r;
    v = 0;
    n = size_of(f3);
    for (int i = 0; i < int'(n); i++)
      v += longint'((w >> (8 * (int'(off) + i))) & 32'hFF) << (8 * i);
    if (!f3[2] && n < 4 && v >= (longint'(1) << (8 * n - 1)))
      v -= (longint'(1) << (8 * n));
    r = 64'(v);
    return r[31:0];
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] old, input logic [31:0] d,
                                              input logic [2:0] f3, input logic [1:0] off);
    logic [7:0] b [4];
    for (int i = 0; i < 4; i++) b[i] = old[8*i +: 8];
    for (int i = 0; i < int'(size_of(f3)); i++) b[int'(off) + i] = d[8*i +: 8];
    return {b[3], b[2], b[1], b[0]};
  endfunction

  // Request-level model: k counts cycles since the accepting edge; done is due at k == lat.
  bit          m_active = 0;
  bit          m_fault = 0;
  bit          m_wr = 0;
  int          m_k = 0;
  int          m_lat = 0;
  int          m_idx = 0;
  logic [31:0] m_addr = 32'h0;
  logic [31:0] m_wword = 32'h0;
  logic [31:0] m_ld_prev = 32'h0;
  logic [31:0] m_ld_new = 32'h0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_active = 0; m_k = 0; m_lat = 0; m_fault = 0; m_wr = 0;
      m_ld_prev = 32'h0; m_ld_new = 32'h0; m_addr = 32'h0;
    end else begin
      bit idle_now;
      idle_now = !m_active || (m_k >= m_lat);
      if (start && idle_now) begin
        m_active  = 1;
        m_k       = 1;
        m_ld_prev = m_ld_new;
        m_addr    = addr;
        m_idx     = int'(addr[9:2]);
        m_wr      = 0;
        m_fault   = model_fault(is_store, funct3, addr);
        if (m_fault) begin
          m_lat = 1;
        end else if (!is_store) begin
          m_lat    = 2;
          m_ld_new = model_load(ref_mem[m_idx], funct3, addr[1:0]);
        end else begin
          m_lat = (size_of(funct3) == 4) ? 2 : 3;
          m_wr  = 1;
          ref_mem[m_idx] = model_store(ref_mem[m_idx], wdata, funct3, addr[1:0]);
          m_wword = ref_mem[m_idx];
        end
      end else if (m_active) begin
        m_k++;
        if (m_k > m_lat) m_active = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      bit in_flight, at_done, wr_now;
      in_flight = m_active && (m_k < m_lat);
      at_done   = m_active && (m_k == m_lat);
      wr_now    = m_active && m_wr && (m_k == m_lat - 1);
      chk("busy", busy, in_flight);
      chk("done", done, at_done);
      chk("fault", fault, at_done && m_fault);
      chk("mem_write", mem_write, wr_now);
      chk("mem_wdata", mem_wdata, wr_now ? m_wword : 32'h0);
      chk("load_data", load_data, in_flight ? m_ld_prev : m_ld_new);
      if (in_flight) chk("mem_addr", mem_addr, m_addr & 32'hFFFF_FFFC);
      if (at_done && m_wr) chk("mem_word", data_mem[m_idx], ref_mem[m_idx]);
    end
  end

  // Caller sits on a falling edge; returns on the done cycle with the measured latency.
  task automatic req(input bit st, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] d, input bit poke, output int lat);
    is_store = st; funct3 = f3; addr = a; wdata = d; start = 1'b1;
    @(negedge clk);
    lat = 1;
    if (poke) begin
      is_store = 1'b0; funct3 = 3'b010; addr = 32'h100;
      @(negedge clk);
      lat = 2;
    end
    start = 1'b0;
    while (!done && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL timeout: no done after %0d cycles", lat);
    end
  endtask

  initial begin
    int lat, w0, n_done, sel;
    bit st;
    logic [2:0] f3;
    logic [31:0] a;
    logic [2:0] legal [5];
    legal[0] = 3'b000; legal[1] = 3'b001; legal[2] = 3'b010; legal[3] = 3'b100; legal[4] = 3'b101;

    for (int i = 0; i < 256; i++) begin
      data_mem[i] = $urandom;
      ref_mem[i]  = data_mem[i];
    end
    data_mem[8'h40] = 32'h8899AABB; ref_mem[8'h40] = 32'h8899AABB;
    data_mem[8'h41] = 32'h11223344; ref_mem[8'h41] = 32'h11223344;

    #1 reset = 1'b1;
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_fault", fault, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_load_data", load_data, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    @(negedge clk);

    req(0, 3'b010, 32'h100, 32'h0, 0, lat);
    chk("lw_lat", lat, 2);
    chk("lw_data", load_data, 32'h8899AABB);
    chk("lw_fault", fault, 0);
    req(0, 3'b000, 32'h103, 32'h0, 0, lat);
    chk("lb_lat_b2b", lat, 2);
    chk("lb_data", load_data, 32'hFFFFFF88);
    req(0, 3'b100, 32'h103, 32'h0, 0, lat);
    chk("lbu_data", load_data, 32'h00000088);
    req(0, 3'b001, 32'h102, 32'h0, 0, lat);
    chk("lh_data", load_data, 32'hFFFF8899);

    @(negedge clk);
    w0 = wr_cnt;
    req(1, 3'b000, 32'h105, 32'h000000A5, 1, lat);
    chk("sb_lat", lat, 3);
    chk("sb_writes", wr_cnt - w0, 1);
    chk("sb_word", data_mem[8'h41], 32'h1122A544);

    w0 = wr_cnt;
    req(1, 3'b001, 32'h101, 32'h1234, 0, lat);
    chk("sh_mis_lat", lat, 1);
    chk("sh_mis_fault", fault, 1);
    req(1, 3'b010, 32'h0FC, 32'hDEADBEEF, 0, lat);
    chk("sw_text_lat", lat, 1);
    chk("sw_text_fault", fault, 1);
    req(0, 3'b010, 32'h400, 32'h0, 0, lat);
    chk("lw_oor_lat", lat, 1);
    chk("lw_oor_fault", fault, 1);
    chk("lw_oor_hold", load_data, 32'hFFFF8899);
    chk("fault_writes", wr_cnt - w0, 0);

    // Reset landing in the write cycle of a sub-word store.
    @(negedge clk);
    is_store = 1'b1; funct3 = 3'b000; addr = 32'h10A; wdata = 32'h5A; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("rst_pre_wr", mem_write, 1);
    #2 reset = 1'b1;
    #1;
    chk("rst_wr_drop", mem_write, 0);
    chk("rst_wr_busy", busy, 0);
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    n_done = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) n_done++;
    end
    chk("rst_no_done", n_done, 0);
    ref_mem[8'h42] = data_mem[8'h42];

    for (int r = 0; r < 400; r++) begin
      sel = $urandom_range(0, 9);
      if (sel < 8)       a = $urandom_range(0, 1023);
      else if (sel == 8) a = $urandom_range(1024, 1100);
      else               a = $urandom;
      f3 = ($urandom_range(0, 9) < 8) ? legal[$urandom_range(0, 4)] : 3'($urandom_range(0, 7));
      st = $urandom_range(0, 1) == 1;
      req(st, f3, a, $urandom, 0, lat);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle load/store sequencer between the control FSM and `data_mem`. It accepts one load or store request, checks alignment and region, and drives the word-addressed memory port. Sub-word stores are done as read-modify-write. Loads return a sign- or zero-extended result held in a register. It is the only master of `data_mem`'s address, write-data and write-enable inputs during data phases.

## Interface
- `MEM_WORDS`, 256: words in `data_mem`; byte addresses ≥ 4·MEM_WORDS are out of range.
- `TEXT_WORDS`, 64: words 0..TEXT_WORDS-1 hold instructions and are store-protected.
- Clock and reset: one clock, `clk`. Reset is `reset`, asynchronous and active-high.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  request strobe; sampled only in IDLE.
- `is_store`  in  1  1 = store, 0 = load.
- `funct3`  in  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `addr`  in  32  byte address.
- `wdata`  in  32  store data; the low bytes are used for B and H.
- `mem_rdata`  in  32  `data_mem.read_data`, a combinational read.
- `mem_addr`  out  32  to `data_mem.address`; always `{addr_q[31:2],2'b00}`.
- `mem_wdata`  out  32  to `data_mem.write_data`.
- `mem_write`  out  1  to `data_mem.mem_write`.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle completion pulse.
- `fault`  out  1  valid with `done`: the request was rejected and memory was untouched.
- `load_data`  out  32  extended load result; holds until the next completed load.

## Operation
- States: IDLE, LD, ST_RD, ST_WR.
- In IDLE, when `start`=1, latch `addr`, `wdata`, `funct3` and `is_store`. Then check the request:
  - Fault if the alignment is wrong: H/HU need `addr[0]`=0; W needs `addr[1:0]`=0.
  - Fault if `funct3` is illegal: 011, 110, 111, or 100/101 with a store.
  - Fault if `addr` ≥ 4·MEM_WORDS.
  - Fault if it is a store with `addr` < 4·TEXT_WORDS.
  - On a fault: stay in IDLE, then pulse `done`=1 and `fault`=1 the next cycle. `load_data` is unchanged.
- Load: IDLE→LD. In LD, `mem_rdata` is extracted by `addr_q[1:0]`, extended per `funct3`, and registered into `load_data`. Then LD→IDLE with a `done` pulse.
- Word store: IDLE→ST_WR. `mem_wdata`=`wdata_q` and `mem_write`=1 for exactly one cycle. Then ST_WR→IDLE with `done`.
- Byte/half store: IDLE→ST_RD. ST_RD registers `mem_rdata` into `old_q`. In ST_WR, `mem_wdata` is `old_q` with the selected lane(s) replaced by `wdata_q[7:0]`/`[15:0]`. Then →IDLE with `done`.
- `mem_write` is 1 only in ST_WR and is decoded from state flops. `mem_wdata` is 0 outside ST_WR.
- `start` while `busy` is ignored; it is not queued. `start` in the same cycle as a `done` pulse is accepted, because the FSM is already in IDLE.
- Reset values: state IDLE, all latches 0, `load_data`=0, `done`=0, `fault`=0, `mem_write`=0, `busy`=0.
- Reset during ST_WR: `mem_write` drops at once (asynchronously). No `done` is issued and the write is not guaranteed.

## Timing
- All outputs are registered or state-decoded; no input reaches an output combinationally.
- Latency from the `start` sample edge to the `done` cycle:
  - Fault: 1.
  - Load: 2.
  - Word store: 2.
  - Sub-word store: 3.
- The memory write happens at the edge that ends ST_WR, which is the same edge that raises `done`.
- `load_data` is valid in the `done` cycle and stays stable afterwards.
- Throughput: one request per latency period. Back-to-back `start` on `done` adds no idle cycle.

## Structure
- `lsu_pkg` contains:
  - the state enum;
  - the `funct3` localparams: F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - the region bounds derived from MEM_WORDS and TEXT_WORDS.
- One combinational sub-module, `lsu_byte_lane`, does two things:
  - load extract/extend, from (word, offset, funct3) to result;
  - store merge, from (old, new, offset, funct3) to word.
- The FSM and all registers stay in `load_store_unit`.

## Test plan
- Load word: memory word 0x40 = 0x8899AABB; LW `addr`=0x100 → `done` 2 cycles after `start`, `load_data`=0x8899AABB, `fault`=0.
- Sign vs zero extend: same word; LB at 0x103 → 0xFFFFFF88; LBU at 0x103 → 0x00000088; LH at 0x102 → 0xFFFF8899.
- Sub-word store read-modify-write: word 0x41 = 0x11223344; SB at 0x105 with `wdata`=0xA5 → exactly one `mem_write` cycle, word becomes 0x1122A544, `done` 3 cycles after `start`.
- Faults:
  - SH at 0x101 → `done`=`fault`=1 one cycle later, `mem_write` never asserted.
  - SW at 0x0FC → same fault response.
  - LW at 0x400 → same fault response, `load_data` unchanged.
- Busy and reset:
  - `start` pulsed in ST_RD is ignored.
  - A new `start` on the `done` cycle is accepted.
  - `reset` asserted in ST_WR → `mem_write`=0 within the same cycle, FSM returns to IDLE, no `done`.
